axi_mem_slave: RTL and testbench
================================

# axi_mem_slave

Memory-side responder for the `axi_if` bus: accepts read and write address handshakes, read/write data transfers and write responses from the bus driver, backed by a 128 × 32-bit word memory. It is the slave end of the same simplified AXI channel set (AR/AW/W/R/B, shared bidirectional data bus) that the testbench driver and monitor use. It is instantiated as the DUT behind the interface in the bus simulation.

## Interface
Parameters:
- `DEPTH`, 128: number of 32-bit words; fixed by the 7-bit `mem_addr`.
- `WAIT_CYCLES`, 2: wait states inserted after an address handshake; used only when `AXI_MEM_SLAVE_WAIT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_data`  inout  32  shared data bus; slave drives it only while `rdata_valid`=1, otherwise high-Z.
- `mem_addr`  in  7  word address; sampled at the AR/AW handshake.
- `ar_valid` / `aw_valid`  in  1  read / write address valid.
- `ar_ready` / `aw_ready`  out  1  read / write address ready.
- `wdata_valid`  in  1  write data valid on `mem_data`.
- `wdata_ready`  out  1  slave accepts write data.
- `rdata_valid`  out  1  read data valid on `mem_data`.
- `rdata_ready`  in  1  master accepts read data.
- `b_valid`  out  1  write response valid.
- `b_ready`  in  1  master accepts write response.

## Operation
- All outputs are registered. Reset value of every output is 0; `mem_data` is released to Z. Memory contents are not reset.
- A transfer occurs on a rising edge where valid and ready are both 1.
- FSM states: `IDLE`, `WAIT`, `WR_DATA`, `WR_RESP`, `RD_DATA`.
- `IDLE`: `ar_ready`=`aw_ready`=1.
  - On an AW handshake: latch `mem_addr` and go to `WR_DATA`.
  - Otherwise, on an AR handshake: latch `mem_addr` and go to `RD_DATA`.
  - If both are valid on the same edge, write wins. `ar_ready` drops, so the read is held and accepted on the next `IDLE`.
- `WR_DATA`: `wdata_ready`=1. On a W handshake, `mem[addr] <= mem_data`; go to `WR_RESP`.
- `WR_RESP`: `b_valid`=1, held until `b_ready`=1 on an edge; then go to `IDLE`.
- `RD_DATA`: `rdata_valid`=1 and `mem_data` driven with `mem[addr]`, held stable until `rdata_ready`=1 on an edge. Then go to `IDLE` and release the bus.
- Only one transaction is outstanding at a time. While not in `IDLE`, both address readies are 0.
- Valids seen in the wrong state (e.g. `wdata_valid` in `IDLE`) are ignored.
- `reset` asserted mid-transaction: immediately return to `IDLE`, clear all outputs, release the bus. A write already committed stays in memory; an uncommitted write is dropped.

## Timing
- `ar_ready`/`aw_ready` first rise on the first edge after `reset` deasserts.
- Write: AW handshake at edge N → `wdata_ready`=1 after edge N. W handshake at edge M → `b_valid`=1 after edge M, data is in memory from edge M.
- Read: AR handshake at edge N → `rdata_valid`=1 and data driven after edge N (one-cycle latency).
- Back-to-back: after the final handshake at edge K, readies are 1 after edge K, so the next address can be accepted at edge K+1.
- Master stalls on `rdata_ready` or `b_ready` are unbounded; there is no timeout.

## Configuration
- `AXI_MEM_SLAVE_WAIT_EN` defined:
  - After any AR/AW handshake, the FSM enters `WAIT` for exactly `WAIT_CYCLES` cycles, with all outputs 0.
  - It then enters `WR_DATA` or `RD_DATA`, so read latency becomes 1+`WAIT_CYCLES`.
  - `WAIT_CYCLES`=0 behaves as undefined.
- Undefined: the `WAIT` state and its counter are not compiled in; `WAIT_CYCLES` is unused.

## Structure
- Package `axi_mem_pkg` holds:
  - `ADDR_W`=7 and `DATA_W`=32.
  - The FSM state enum `axi_mem_state_t`.
- Sub-module `axi_mem_array` holds the `DEPTH`×`DATA_W` storage: synchronous write enable, combinational read, no reset.
- `axi_mem_slave` contains the FSM, address latch, wait counter and tri-state data drive.

## Test plan
- Reset: hold `reset`=0 for 3 cycles → all outputs 0, `mem_data`=Z; after release, `ar_ready`=`aw_ready`=1 one edge later.
- Write then read: write `0xDEADBEEF` to addr `0x05`, `b_ready`=1 → `b_valid` for 1 cycle. Read addr `0x05` → `rdata_valid` one cycle after the AR handshake, with `mem_data`=`0xDEADBEEF`.
- Backpressure: read addr `0x7F` (previously written `0x12345678`) with `rdata_ready` held 0 for 5 cycles → `rdata_valid` and data stay stable for 5 cycles and clear on the edge after `rdata_ready`=1.
- Simultaneous: `ar_valid`=`aw_valid`=1 on the same edge, addr `0x10`, write data `0xA5A5A5A5` → write completes first. The read is then accepted and returns `0xA5A5A5A5`.
- Mid-write reset: assert `reset` while in `WR_DATA` for addr `0x20`, which previously held `0x11111111` → `wdata_ready` drops at once, FSM returns to `IDLE`, and a later read of `0x20` returns `0x11111111`.
- With `AXI_MEM_SLAVE_WAIT_EN` and `WAIT_CYCLES`=2: a read of addr `0x05` → `rdata_valid` rises exactly 3 cycles after the AR handshake.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared widths and FSM state encoding for the axi_mem_slave memory responder.
package axi_mem_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_DATA = 3'd4
  } axi_mem_state_t;
endpackage

// File: rtl/axi_if.sv
// Simplified AXI channel set (AR/AW/W/R/B); the 32-bit data bus is a shared inout net
// carried as a plain port next to this interface.
interface axi_if;
  import axi_mem_pkg::*;

  // Every channel transfers on a rising edge where its valid and ready are both 1;
  // a valid may be raised before ready and is simply ignored in states that do not consume it.
  logic [ADDR_W-1:0] mem_addr;
  logic              ar_valid;
  logic              ar_ready;
  logic              aw_valid;
  logic              aw_ready;
  logic              wdata_valid;
  logic              wdata_ready;
  logic              rdata_valid;
  logic              rdata_ready;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output mem_addr, ar_valid, aw_valid, wdata_valid, rdata_ready, b_ready,
    input  ar_ready, aw_ready, wdata_ready, rdata_valid, b_valid
  );

  modport slave (
    input  mem_addr, ar_valid, aw_valid, wdata_valid, rdata_ready, b_ready,
    output ar_ready, aw_ready, wdata_ready, rdata_valid, b_valid
  );
endinterface

// File: rtl/axi_mem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read, contents not reset.
module axi_mem_array
  import axi_mem_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_mem_slave.sv
// Single-outstanding AXI-style memory responder; define AXI_MEM_SLAVE_WAIT_EN to insert
// WAIT_CYCLES wait states after each address handshake.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  inout  wire  [DATA_W-1:0]    mem_data,
  axi_if.slave                 bus,
  output axi_mem_state_t       state_dbg
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_word;
  logic              ar_ready_q, aw_ready_q, wdata_ready_q, rdata_valid_q, b_valid_q;
  logic              aw_hs, ar_hs, w_hs, r_hs, b_hs;

  // Write wins a simultaneous AR/AW; the read stays pending on the bus until the next IDLE.
  assign aw_hs = bus.aw_valid & aw_ready_q;
  assign ar_hs = bus.ar_valid & ar_ready_q & ~aw_hs;
  assign w_hs  = bus.wdata_valid & wdata_ready_q;
  assign r_hs  = rdata_valid_q & bus.rdata_ready;
  assign b_hs  = b_valid_q & bus.b_ready;

`ifdef AXI_MEM_SLAVE_WAIT_EN
  localparam logic [2:0] WAIT     = 3'd1;
  localparam bit         USE_WAIT = (WAIT_CYCLES > 0);
  localparam int         CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             pend_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      pend_wr  <= 1'b0;
    end else if (aw_hs || ar_hs) begin
      wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
      pend_wr  <= aw_hs;
    end else if (state == WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (aw_hs || ar_hs) begin
`ifdef AXI_MEM_SLAVE_WAIT_EN
          state_n = USE_WAIT ? WAIT : (aw_hs ? WR_DATA : RD_DATA);
`else
          state_n = aw_hs ? WR_DATA : RD_DATA;
`endif
        end
      end
`ifdef AXI_MEM_SLAVE_WAIT_EN
      WAIT:    if (wait_cnt == '0) state_n = pend_wr ? WR_DATA : RD_DATA;
`endif
      WR_DATA: if (w_hs) state_n = WR_RESP;
      WR_RESP: if (b_hs) state_n = IDLE;
      RD_DATA: if (r_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      ar_ready_q    <= 1'b0;
      aw_ready_q    <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      b_valid_q     <= 1'b0;
    end else begin
      state         <= state_n;
      if (aw_hs || ar_hs) addr_q <= bus.mem_addr;
      ar_ready_q    <= (state_n == IDLE);
      aw_ready_q    <= (state_n == IDLE);
      wdata_ready_q <= (state_n == WR_DATA);
      rdata_valid_q <= (state_n == RD_DATA);
      b_valid_q     <= (state_n == WR_RESP);
    end
  end

  axi_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (w_hs),
    .waddr (addr_q),
    .wdata (mem_data),
    .raddr (addr_q),
    .rdata (rd_word)
  );

  assign mem_data        = rdata_valid_q ? rd_word : {DATA_W{1'bz}};
  assign bus.ar_ready    = ar_ready_q;
  assign bus.aw_ready    = aw_ready_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.b_valid     = b_valid_q;
  assign state_dbg       = axi_mem_state_t'(state);
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed write/read, backpressure, AR/AW collision,
// mid-write reset and a short random sweep, with read data checked through an expected queue.
module tb_axi_mem_slave;
  import axi_mem_pkg::*;

  localparam int WAIT_CYCLES = 2;
`ifdef AXI_MEM_SLAVE_WAIT_EN
  localparam int RD_LAT = 1 + WAIT_CYCLES;
  localparam logic [31:0] POST_AW_STATE = 32'(ST_WAIT);
`else
  localparam int RD_LAT = 1;
  localparam logic [31:0] POST_AW_STATE = 32'(ST_WR_DATA);
`endif
  localparam int S_AW = 0, S_AR = 1, S_WR = 2, S_RV = 3, S_BV = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wire  [DATA_W-1:0] mem_data;
  logic              tb_drive = 1'b0;
  logic [DATA_W-1:0] tb_data  = '0;
  axi_mem_state_t    state_dbg;

  axi_if bus ();

  assign mem_data = tb_drive ? tb_data : {DATA_W{1'bz}};

  axi_mem_slave #(.DEPTH(128), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_data  (mem_data),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model [128];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_AW:    return bus.aw_ready;
      S_AR:    return bus.ar_ready;
      S_WR:    return bus.wdata_ready;
      S_RV:    return bus.rdata_valid;
      S_BV:    return bus.b_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_high(input string tag, input int sel);
    int n = 0;
    while (!sig(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_data_phase(input logic [DATA_W-1:0] d);
    tb_drive = 1'b1;
    tb_data  = d;
    bus.wdata_valid = 1'b1;
    wait_high("wr", S_WR);
    @(negedge clk);
    bus.wdata_valid = 1'b0;
    tb_drive = 1'b0;
    check("b_valid", 32'(bus.b_valid), 32'd1);
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    check("b_clear", 32'(bus.b_valid), 32'd0);
    check("wr_aw_ready", 32'(bus.aw_ready), 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.mem_addr = a;
    bus.aw_valid = 1'b1;
    wait_high("aw", S_AW);
    @(negedge clk);
    bus.aw_valid = 1'b0;
    write_data_phase(d);
    model[a] = d;
  endtask

  // Called on the first negedge after the AR handshake edge.
  task automatic finish_read(input int stall);
    int lat = 1;
    logic [DATA_W-1:0] got, e;
    while (!bus.rdata_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rd_lat", 32'(lat), 32'(RD_LAT));
    got = mem_data;
    e = exp_q.pop_front();
    check("rd_data", got, e);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rd_hold_v", 32'(bus.rdata_valid), 32'd1);
      check("rd_hold_d", mem_data, got);
    end
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    bus.rdata_ready = 1'b0;
    check("rd_clear", 32'(bus.rdata_valid), 32'd0);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int stall);
    exp_q.push_back(model[a]);
    bus.mem_addr = a;
    bus.ar_valid = 1'b1;
    wait_high("ar", S_AR);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    finish_read(stall);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.mem_addr = '0;
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.wdata_valid = 1'b0;
    bus.rdata_ready = 1'b0;
    bus.b_ready = 1'b0;

    // reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_ar_ready", 32'(bus.ar_ready), 32'd0);
    check("rst_aw_ready", 32'(bus.aw_ready), 32'd0);
    check("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    check("rst_b_valid", 32'(bus.b_valid), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    #1;
    check("rel_ar_ready_pre", 32'(bus.ar_ready), 32'd0);
    @(negedge clk);
    check("rel_ar_ready", 32'(bus.ar_ready), 32'd1);
    check("rel_aw_ready", 32'(bus.aw_ready), 32'd1);

    // write then read
    do_write(7'h05, 32'hDEADBEEF);
    do_read(7'h05, 0);

    // backpressure on R
    do_write(7'h7F, 32'h12345678);
    do_read(7'h7F, 5);

    // stray valids in IDLE are ignored
    tb_drive = 1'b1;
    tb_data = 32'hFFFF_0000;
    bus.wdata_valid = 1'b1;
    bus.b_ready = 1'b1;
    bus.rdata_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_state", 32'(state_dbg), 32'(ST_IDLE));
    check("stray_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    bus.wdata_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.rdata_ready = 1'b0;
    tb_drive = 1'b0;
    do_read(7'h05, 1);

    // simultaneous AR and AW: write first, then the held read
    bus.mem_addr = 7'h10;
    bus.aw_valid = 1'b1;
    bus.ar_valid = 1'b1;
    check("sim_aw_ready", 32'(bus.aw_ready), 32'd1);
    @(negedge clk);
    bus.aw_valid = 1'b0;
    check("sim_ar_held", 32'(bus.ar_ready), 32'd0);
    check("sim_state", 32'(state_dbg), POST_AW_STATE);
    write_data_phase(32'hA5A5A5A5);
    model[7'h10] = 32'hA5A5A5A5;
    exp_q.push_back(model[7'h10]);
    wait_high("sim_ar", S_AR);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    finish_read(0);

    // reset during WR_DATA drops the uncommitted write
    do_write(7'h20, 32'h11111111);
    bus.mem_addr = 7'h20;
    bus.aw_valid = 1'b1;
    wait_high("mr_aw", S_AW);
    @(negedge clk);
    bus.aw_valid = 1'b0;
    wait_high("mr_wr", S_WR);
    reset = 1'b0;
    tb_drive = 1'b1;
    tb_data = 32'hBAD0BAD0;
    bus.wdata_valid = 1'b1;
    #1;
    check("mr_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("mr_state", 32'(state_dbg), 32'(ST_IDLE));
    check("mr_ar_ready", 32'(bus.ar_ready), 32'd0);
    repeat (2) @(negedge clk);
    bus.wdata_valid = 1'b0;
    tb_drive = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mr_rel_ready", 32'(bus.ar_ready), 32'd1);
    do_read(7'h20, 0);

    // short random sweep
    for (int i = 0; i < 6; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = ADDR_W'($urandom_range(8'h30, 8'h6F));
      d = $urandom;
      do_write(a, d);
      do_read(a, $urandom_range(0, 3));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
